// File: rtl/button_debounce_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce_scheduler
// Description : Four-channel push-button debouncer. A free-running prescaler
//               produces a sample tick; on each tick an FSM walks a single
//               shared saturating-integrator datapath across the channels,
//               one channel per clock. Every debounced level change is
//               queued as an event in a 4-entry first-word-fall-through FIFO.
//
// Ports       : clk        in   system clock, all state updates on posedge
//               rst        in   synchronous active-high reset
//               btn_in     in   raw asynchronous button levels (bit k = ch k)
//               btn_state  out  debounced level per channel
//               evt_valid  out  event FIFO head valid
//               evt_ready  in   consumer takes the head when evt_valid=1
//               evt_btn    out  channel index of the head event
//               evt_press  out  1 = press (0->1), 0 = release (1->0)
//               overflow   out  sticky: an event was dropped (FIFO full)
//
// Revision    : 1.0 - initial release
// ============================================================================
module button_debounce_scheduler #(
    parameter int N_BTN    = 4,
    parameter int TICK_DIV = 100000,
    parameter int THRESH   = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_state,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [1:0]       evt_btn,
    output logic             evt_press,
    output logic             overflow
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int              c_PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(TICK_DIV - 1);
    localparam logic [3:0]      c_THRESH    = 4'(THRESH);
    localparam logic [1:0]      c_LAST_CH   = 2'd3;

    localparam logic [0:0]      c_ST_IDLE   = 1'b0;
    localparam logic [0:0]      c_ST_SCAN   = 1'b1;

    // ------------------------------------------------------------------------
    // Two-flop synchronizer; only r_sync2 is used by downstream logic.
    // ------------------------------------------------------------------------
    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------------
    // Sample-tick prescaler. Runs freely, including while a scan is in
    // progress; the minimum divide ratio keeps ticks out of the scan window.
    // ------------------------------------------------------------------------
    logic [c_PW-1:0] r_presc;
    logic            w_tick;

    assign w_tick = (r_presc == c_PRESC_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Scan FSM: IDLE waits for a tick, SCAN evaluates one channel per clock.
    // ------------------------------------------------------------------------
    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic [1:0] r_ch;
    logic [1:0] w_ch_nxt;
    logic       w_eval;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_ch    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ch    <= w_ch_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ch_nxt    = r_ch;
        w_eval      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_tick) begin
                    w_state_nxt = c_ST_SCAN;
                    w_ch_nxt    = '0;
                end
            end
            c_ST_SCAN: begin
                w_eval   = 1'b1;
                w_ch_nxt = r_ch + 2'd1;
                if (r_ch == c_LAST_CH) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_ch_nxt    = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Shared integrator datapath, applied to channel r_ch while scanning.
    // The counter saturates at both ends; the debounced level only flips at
    // the extremes, which gives hysteresis for values in between.
    // ------------------------------------------------------------------------
    logic [3:0]       r_cnt [N_BTN];
    logic [N_BTN-1:0] r_btn_state;
    logic [3:0]       w_cnt_cur;
    logic [3:0]       w_cnt_new;
    logic             w_smp;
    logic             w_lvl_cur;
    logic             w_push;
    logic [2:0]       w_push_data;

    assign w_cnt_cur = r_cnt[r_ch];
    assign w_smp     = r_sync2[r_ch];
    assign w_lvl_cur = r_btn_state[r_ch];

    always_comb begin
        w_cnt_new = w_cnt_cur;
        if (w_smp) begin
            if (w_cnt_cur < c_THRESH) begin
                w_cnt_new = w_cnt_cur + 4'd1;
            end else begin
                w_cnt_new = c_THRESH;
            end
        end else begin
            if (w_cnt_cur != 4'd0) begin
                w_cnt_new = w_cnt_cur - 4'd1;
            end
        end
    end

    // A change is produced only when the new count hits the extreme opposite
    // to the current level; since THRESH >= 1 both cases are exclusive.
    assign w_push = w_eval &&
                    (((w_cnt_new == c_THRESH) && !w_lvl_cur) ||
                     ((w_cnt_new == 4'd0)     &&  w_lvl_cur));
    assign w_push_data = {r_ch, ~w_lvl_cur};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_BTN; i++) begin
                r_cnt[i] <= '0;
            end
            r_btn_state <= '0;
        end else if (w_eval) begin
            r_cnt[r_ch] <= w_cnt_new;
            if (w_push) begin
                r_btn_state[r_ch] <= ~w_lvl_cur;
            end
        end
    end

    assign btn_state = r_btn_state;

    // ------------------------------------------------------------------------
    // Event FIFO: 4 entries of {channel, level}, first-word-fall-through.
    // A push into a full FIFO is still accepted when the head pops on the
    // same edge; otherwise it is dropped and overflow latches.
    // ------------------------------------------------------------------------
    logic [2:0] r_mem [4];
    logic [1:0] r_wptr;
    logic [1:0] r_rptr;
    logic [2:0] r_count;
    logic       r_overflow;
    logic       w_empty;
    logic       w_full;
    logic       w_pop;
    logic       w_wr;

    assign w_empty = (r_count == 3'd0);
    assign w_full  = (r_count == 3'd4);
    assign w_pop   = !w_empty && evt_ready;
    assign w_wr    = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wptr] <= w_push_data;
                r_wptr        <= r_wptr + 2'd1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 2'd1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Head fields read as zero while empty so reset/idle outputs are clean.
    assign evt_valid            = !w_empty;
    assign {evt_btn, evt_press} = w_empty ? 3'b000 : r_mem[r_rptr];
    assign overflow             = r_overflow;

endmodule
`default_nettype wire
